// File: rtl/chess_pkg.sv
// Shared piece codes, controller states, the initial position and ownership helpers
// for the chess move controller.
package chess_pkg;

   localparam logic [3:0] P_EMPTY    = 4'd0;
   localparam logic [3:0] P_W_PAWN   = 4'd1;
   localparam logic [3:0] P_W_BISHOP = 4'd2;
   localparam logic [3:0] P_W_KNIGHT = 4'd3;
   localparam logic [3:0] P_W_ROOK   = 4'd4;
   localparam logic [3:0] P_W_QUEEN  = 4'd5;
   localparam logic [3:0] P_W_KING   = 4'd6;
   localparam logic [3:0] P_B_PAWN   = 4'd7;
   localparam logic [3:0] P_B_BISHOP = 4'd8;
   localparam logic [3:0] P_B_KNIGHT = 4'd9;
   localparam logic [3:0] P_B_ROOK   = 4'd10;
   localparam logic [3:0] P_B_QUEEN  = 4'd11;
   localparam logic [3:0] P_B_KING   = 4'd12;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_PICKED,
      S_COMMIT,
      S_OVER
   } state_t;

   // Cell i = r*8+c; the most significant nibble is row 7, col 7.
   localparam logic [63:0][3:0] INIT_BOARD =
      256'hA98CB89A_77777777_00000000_00000000_00000000_00000000_11111111_43265234;

   function automatic logic is_white(input logic [3:0] code);
      return (code >= P_W_PAWN) && (code <= P_W_KING);
   endfunction

   function automatic logic is_black(input logic [3:0] code);
      return (code >= P_B_PAWN) && (code <= P_B_KING);
   endfunction

   function automatic logic is_own(input logic [3:0] code, input logic turn);
      return turn ? is_black(code) : is_white(code);
   endfunction

endpackage

// File: rtl/chess_move_controller.sv
// Owns the board, turns select/target clicks into committed moves using the
// legal-move mask returned by the combinational move generator.
module chess_move_controller
   import chess_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          new_game,
   input  logic          click_valid,
   input  logic [5:0]    click_pos,
   output logic          click_ready,
   output logic [4:0]    sel_figure,
   output logic [5:0]    sel_pos,
   input  logic [63:0]   moves_mask,
   output logic [63:0]   highlight,
   output logic [255:0]  board_flat,
   output logic          turn,
   output logic          move_done,
   output logic [5:0]    move_from,
   output logic [5:0]    move_to,
   output logic [3:0]    captured,
   output logic          illegal,
   output logic          game_over
);

   state_t             r_state, w_state_nxt;
   logic [63:0][3:0]   r_board;
   logic [3:0]         r_sel_fig;
   logic [5:0]         r_sel_pos;
   logic [5:0]         r_tgt;
   logic [63:0]        r_highlight;
   logic               r_turn;
   logic               r_move_done;
   logic [5:0]         r_move_from;
   logic [5:0]         r_move_to;
   logic [3:0]         r_captured;
   logic               r_illegal;
   logic               r_game_over;

   logic               w_accept;
   logic [3:0]         w_click_code;
   logic               w_click_own;
   logic [3:0]         w_to_code;
   logic [3:0]         w_fig;
   logic               w_sel_load;
   logic               w_deselect;
   logic               w_tgt_load;
   logic               w_fetch;
   logic               w_commit;
   logic               w_illegal;

   assign click_ready  = (r_state == S_IDLE) || (r_state == S_PICKED) || (r_state == S_OVER);
   assign w_accept     = click_valid && click_ready;
   assign w_click_code = r_board[click_pos];
   assign w_click_own  = is_own(w_click_code, r_turn);
   assign w_to_code    = r_board[r_tgt];

   // Pawns reaching the far rank are promoted to a queen of their colour.
   always_comb begin
      w_fig = r_sel_fig;
      if (r_sel_fig == P_W_PAWN && r_tgt[5:3] == 3'd7)
         w_fig = P_W_QUEEN;
      else if (r_sel_fig == P_B_PAWN && r_tgt[5:3] == 3'd0)
         w_fig = P_B_QUEEN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_load  = 1'b0;
      w_deselect  = 1'b0;
      w_tgt_load  = 1'b0;
      w_fetch     = 1'b0;
      w_commit    = 1'b0;
      w_illegal   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_click_own) begin
                  w_sel_load  = 1'b1;
                  w_state_nxt = S_FETCH;
               end else begin
                  w_illegal = 1'b1;
               end
            end
         end
         S_FETCH: begin
            w_fetch     = 1'b1;
            w_state_nxt = S_PICKED;
         end
         S_PICKED: begin
            if (w_accept) begin
               if (click_pos == r_sel_pos) begin
                  w_deselect  = 1'b1;
                  w_state_nxt = S_IDLE;
               end else if (w_click_own) begin
                  w_sel_load  = 1'b1;
                  w_state_nxt = S_FETCH;
               end else if (r_highlight[click_pos]) begin
                  w_tgt_load  = 1'b1;
                  w_state_nxt = S_COMMIT;
               end else begin
                  w_illegal = 1'b1;
               end
            end
         end
         S_COMMIT: begin
            w_commit    = 1'b1;
            w_state_nxt = (w_to_code == P_W_KING || w_to_code == P_B_KING) ? S_OVER : S_IDLE;
         end
         S_OVER: ;
         default: w_state_nxt = S_IDLE;
      endcase
      // new_game overrides any click decision taken in the same cycle
      if (new_game)
         w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_board     <= INIT_BOARD;
         r_sel_fig   <= '0;
         r_sel_pos   <= '0;
         r_tgt       <= '0;
         r_highlight <= '0;
         r_turn      <= 1'b0;
         r_move_done <= 1'b0;
         r_move_from <= '0;
         r_move_to   <= '0;
         r_captured  <= '0;
         r_illegal   <= 1'b0;
         r_game_over <= 1'b0;
      end else if (new_game) begin
         r_board     <= INIT_BOARD;
         r_sel_fig   <= '0;
         r_sel_pos   <= '0;
         r_tgt       <= '0;
         r_highlight <= '0;
         r_turn      <= 1'b0;
         r_move_done <= 1'b0;
         r_move_from <= '0;
         r_move_to   <= '0;
         r_captured  <= '0;
         r_illegal   <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_illegal   <= w_illegal;
         r_move_done <= w_commit;
         if (w_sel_load) begin
            r_sel_pos <= click_pos;
            r_sel_fig <= w_click_code;
         end
         if (w_deselect) begin
            r_highlight <= '0;
            r_sel_fig   <= '0;
         end
         if (w_fetch)
            r_highlight <= moves_mask;
         if (w_tgt_load)
            r_tgt <= click_pos;
         if (w_commit) begin
            r_board[r_sel_pos] <= P_EMPTY;
            r_board[r_tgt]     <= w_fig;
            r_captured         <= w_to_code;
            r_move_from        <= r_sel_pos;
            r_move_to          <= r_tgt;
            r_turn             <= ~r_turn;
            r_highlight        <= '0;
            r_sel_fig          <= '0;
            if (w_to_code == P_W_KING || w_to_code == P_B_KING)
               r_game_over <= 1'b1;
         end
      end
   end

   assign sel_figure = {1'b0, r_sel_fig};
   assign sel_pos    = r_sel_pos;
   assign highlight  = r_highlight;
   assign board_flat = r_board;
   assign turn       = r_turn;
   assign move_done  = r_move_done;
   assign move_from  = r_move_from;
   assign move_to    = r_move_to;
   assign captured   = r_captured;
   assign illegal    = r_illegal;
   assign game_over  = r_game_over;

endmodule

// File: tb/tb_chess_move_controller.sv
// Directed bench for chess_move_controller: the bench plays the move generator by
// driving moves_mask and checks outputs against hand-computed board states.
module tb_chess_move_controller;

   localparam logic [255:0] INIT =
      256'hA98CB89A_77777777_00000000_00000000_00000000_00000000_11111111_43265234;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          new_game = 1'b0;
   logic          click_valid = 1'b0;
   logic [5:0]    click_pos = '0;
   logic          click_ready;
   logic [4:0]    sel_figure;
   logic [5:0]    sel_pos;
   logic [63:0]   moves_mask = '0;
   logic [63:0]   highlight;
   logic [255:0]  board_flat;
   logic          turn;
   logic          move_done;
   logic [5:0]    move_from;
   logic [5:0]    move_to;
   logic [3:0]    captured;
   logic          illegal;
   logic          game_over;

   logic [63:0][3:0] exp_board;
   logic             exp_turn;
   int               n_vec = 0;
   int               n_err = 0;

   chess_move_controller dut (
      .clk         (clk),
      .rst         (rst),
      .new_game    (new_game),
      .click_valid (click_valid),
      .click_pos   (click_pos),
      .click_ready (click_ready),
      .sel_figure  (sel_figure),
      .sel_pos     (sel_pos),
      .moves_mask  (moves_mask),
      .highlight   (highlight),
      .board_flat  (board_flat),
      .turn        (turn),
      .move_done   (move_done),
      .move_from   (move_from),
      .move_to     (move_to),
      .captured    (captured),
      .illegal     (illegal),
      .game_over   (game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Presents one click for a single edge; returns on the negedge after acceptance.
   task automatic click(input logic [5:0] pos);
      @(negedge clk);
      click_valid = 1'b1;
      click_pos   = pos;
      @(negedge clk);
      click_valid = 1'b0;
   endtask

   task automatic do_move(input logic [5:0] from, input logic [5:0] to,
                          input logic [3:0] fig, input logic [3:0] cap);
      moves_mask = 64'd1 << to;
      click(from);
      chk("sel_pos", sel_pos, from);
      step();
      chk("hl_fetch", highlight, moves_mask);
      click(to);
      chk("ready_commit", click_ready, 1'b0);
      step();
      exp_board[from] = 4'd0;
      exp_board[to]   = fig;
      exp_turn        = ~exp_turn;
      chk("move_done", move_done, 1'b1);
      chk("board", board_flat, exp_board);
      chk("captured", captured, cap);
      chk("turn", turn, exp_turn);
      chk("move_from", move_from, from);
      chk("move_to", move_to, to);
      chk("hl_clear", highlight, 64'd0);
      chk("selfig_clear", sel_figure, 5'd0);
   endtask

   initial begin
      exp_board = INIT;
      exp_turn  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_board", board_flat, INIT);
      chk("rst_ready", click_ready, 1'b1);
      rst = 1'b0;
      step();
      chk("rst_board2", board_flat, INIT);
      chk("rst_turn", turn, 1'b0);
      chk("rst_ready2", click_ready, 1'b1);
      chk("rst_pulses", {move_done, illegal, game_over}, 3'b000);
      chk("rst_hl", highlight, 64'd0);
      chk("rst_sel", {sel_figure, sel_pos}, 11'd0);

      // White e-pawn with two candidate targets
      moves_mask = (64'd1 << 20) | (64'd1 << 28);
      click(6'd12);
      chk("sel_fig_pawn", sel_figure, 5'd1);
      chk("ready_fetch", click_ready, 1'b0);
      step();
      chk("hl_two", highlight, 64'h0000_0000_1010_0000);
      click(6'd28);
      step();
      exp_board[12] = 4'd0; exp_board[28] = 4'd1; exp_turn = 1'b1;
      chk("m1_done", move_done, 1'b1);
      chk("m1_c28", board_flat[4*28 +: 4], 4'd1);
      chk("m1_c12", board_flat[4*12 +: 4], 4'd0);
      chk("m1_cap", captured, 4'd0);
      chk("m1_turn", turn, 1'b1);
      step();
      chk("m1_pulse_end", move_done, 1'b0);

      // Black to move: white piece is not own
      click(6'd0);
      chk("ill_white", illegal, 1'b1);
      step();
      chk("ill_pulse_end", illegal, 1'b0);
      chk("ill_board", board_flat, exp_board);

      // Off-mask target keeps the selection and its highlight
      moves_mask = 64'd1 << 40;
      click(6'd48);
      step();
      click(6'd33);
      chk("ill_offmask", illegal, 1'b1);
      chk("hl_kept", highlight, 64'd1 << 40);
      click(6'd40);
      step();
      exp_board[48] = 4'd0; exp_board[40] = 4'd7; exp_turn = 1'b0;
      chk("m2_board", board_flat, exp_board);
      chk("m2_turn", turn, 1'b0);

      // White to move: black pawn rejected
      click(6'd49);
      chk("ill_black", illegal, 1'b1);
      chk("ill_sel_keep", sel_pos, 6'd48);

      // Deselect, then reselect with a fresh mask
      moves_mask = 64'd1 << 19;
      click(6'd11);
      step();
      click(6'd11);
      chk("desel_hl", highlight, 64'd0);
      chk("desel_ready", click_ready, 1'b1);
      click(6'd11);
      step();
      moves_mask = 64'd1 << 18;
      click(6'd10);
      chk("resel_pos", sel_pos, 6'd10);
      step();
      chk("resel_hl", highlight, 64'd1 << 18);
      click(6'd10);
      chk("desel2_hl", highlight, 64'd0);

      // Bench-chosen masks walk the pieces into the promotion and king-capture positions
      do_move(6'd11, 6'd50, 4'd1, 4'd7);
      do_move(6'd59, 6'd43, 4'd11, 4'd0);
      do_move(6'd8,  6'd16, 4'd1, 4'd0);
      do_move(6'd56, 6'd59, 4'd10, 4'd0);
      do_move(6'd50, 6'd59, 4'd5, 4'd10);
      do_move(6'd49, 6'd1,  4'd11, 4'd3);
      do_move(6'd59, 6'd60, 4'd5, 4'd12);
      chk("go_set", game_over, 1'b1);
      click(6'd5);
      chk("over_ready", click_ready, 1'b1);
      chk("over_noill", illegal, 1'b0);
      step();
      chk("over_board", board_flat, exp_board);

      // new_game restores everything
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      exp_board = INIT; exp_turn = 1'b0;
      chk("ng_board", board_flat, INIT);
      chk("ng_go", game_over, 1'b0);
      chk("ng_turn", turn, 1'b0);
      chk("ng_move", {move_from, move_to, captured}, 16'd0);

      // new_game beats a simultaneous legal target click
      moves_mask = 64'd1 << 28;
      click(6'd12);
      step();
      @(negedge clk);
      click_valid = 1'b1; click_pos = 6'd28; new_game = 1'b1;
      @(negedge clk);
      click_valid = 1'b0; new_game = 1'b0;
      step();
      chk("ngc_done", move_done, 1'b0);
      chk("ngc_board", board_flat, INIT);
      chk("ngc_turn", turn, 1'b0);
      chk("ngc_hl", highlight, 64'd0);
      chk("ngc_ready", click_ready, 1'b1);

      // Reset in COMMIT leaves no partial write
      click(6'd12);
      step();
      click(6'd28);
      chk("pre_rst_ready", click_ready, 1'b0);
      rst = 1'b1;
      #1;
      chk("rstc_board", board_flat, INIT);
      chk("rstc_ready", click_ready, 1'b1);
      chk("rstc_sel", {sel_figure, sel_pos}, 11'd0);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("rstc_board2", board_flat, INIT);
      chk("rstc_done", move_done, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/chess_move_controller.md
# chess_move_controller

Sequential controller that owns the chessboard state and turns player clicks into committed moves. It sits directly upstream of the combinational move-generation stage: it drives that stage's selected-figure code and square position, registers the returned 64-bit legal-move mask, validates the player's target click against it, and updates the board. The controller's outputs feed the display and the game-status logic.

## Interface
Parameters: none; all constants live in `chess_pkg`.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `new_game`  in  1  synchronous reload of the initial position and game state
- `click_valid`  in  1  click request
- `click_pos`  in  6  clicked square; [5:3] row, [2:0] col
- `click_ready`  out  1  click accepted when `click_valid && click_ready`
- `sel_figure`  out  5  code of the selected piece, zero-extended 4-bit code; drives move generation
- `sel_pos`  out  6  selected square; drives move generation
- `moves_mask`  in  64  legal-target mask from move generation, bit r*8+c
- `highlight`  out  64  registered mask while a piece is selected, else 0
- `board_flat`  out  256  cell i = r*8+c occupies bits [4i+3:4i]
- `turn`  out  1  0 = white to move, 1 = black to move
- `move_done`  out  1  one-cycle pulse on commit
- `move_from`, `move_to`  out  6 each  squares of the last committed move
- `captured`  out  4  code previously on `move_to`; 0 if the target was empty
- `illegal`  out  1  one-cycle pulse when an accepted click is rejected
- `game_over`  out  1  set when a king is captured

## Operation
- Piece codes:
  - 0 = empty
  - White pieces: 1 pawn, 2 bishop, 3 knight, 4 rook, 5 queen, 6 king
  - Black pieces: 7 pawn, 8 bishop, 9 knight, 10 rook, 11 queen, 12 king
  - An "own" piece is a code in 1..6 when `turn`=0, or a code in 7..12 when `turn`=1.
- Initial board:
  - Row 0: 4,3,2,5,6,2,3,4
  - Row 1: all 1
  - Rows 2–5: all 0
  - Row 6: all 7
  - Row 7: 10,9,8,11,12,8,9,10
- States: IDLE, FETCH, PICKED, COMMIT, OVER.
- IDLE:
  - Accepted click on an own piece: latch `sel_pos` and `sel_figure`, go to FETCH.
  - Any other accepted click: pulse `illegal`, stay in IDLE.
- FETCH:
  - `click_ready`=0.
  - Register `moves_mask` into `highlight`, go to PICKED.
- PICKED, on an accepted click:
  - Same square as `sel_pos`: deselect, clear `highlight`, go to IDLE.
  - Another own piece: reselect, go to FETCH.
  - Square whose `highlight` bit is 1: latch the target, go to COMMIT.
  - Any other square: pulse `illegal`, stay in PICKED.
- COMMIT (`click_ready`=0):
  - Board update: `board[to]` ← figure, `board[from]` ← 0, `captured` ← old `board[to]`.
  - Promotion: a white pawn landing on row 7 becomes 5; a black pawn landing on row 0 becomes 11.
  - Outputs: pulse `move_done`, update `move_from`/`move_to`, toggle `turn`, clear `highlight`, clear `sel_figure`.
  - If the captured code is 6 or 12: set `game_over`, go to OVER. Otherwise go to IDLE.
- OVER:
  - `click_ready`=1.
  - All clicks are silently dropped: no `illegal` pulse.
- `new_game`:
  - Valid in any state: reloads the initial board, sets `turn`=0, clears `highlight`, `game_over`, `sel_*`, `move_*` and `captured`, then goes to IDLE.
  - Has priority over a simultaneous click; that click is dropped.

## Timing
- Reset values:
  - Board = initial position; state IDLE.
  - `click_ready`=1.
  - `turn`, `move_done`, `illegal`, `game_over` = 0.
  - `highlight`, `sel_figure`, `sel_pos`, `move_from`, `move_to`, `captured` = 0.
- All outputs are registered; `click_ready` is decoded from the registered state.
- Move generation is combinational. `moves_mask` is sampled exactly one cycle after `sel_*` changes, in FETCH.
- Click on own piece → `highlight` valid 2 cycles later.
- Legal target click → `move_done` and the new board visible 2 cycles after acceptance (PICKED→COMMIT, then registered outputs).
- `illegal` pulses the cycle after the rejected click is accepted.
- Back-to-back clicks are allowed whenever `click_ready`=1. A click presented while `click_ready`=0 is held off, not lost, provided the source holds `click_valid`.
- `rst` asserted mid-move returns to the reset values immediately; no partial board write survives.

## Structure
- `chess_pkg` contains:
  - Piece-code localparams
  - State enum
  - `INIT_BOARD` constant (64×4)
  - Functions `is_white`, `is_black`, `is_own(code, turn)`
- Flat module, no sub-module. Board storage is 64 4-bit registers written at two cells per commit.

## Test plan
- Reset → `board_flat` equals the initial position, `turn`=0, `click_ready`=1, all pulses 0.
- White: click (1,4) with `moves_mask` = bits 20 and 28 → `highlight`=0x10100000 two cycles later. Then click (3,4) → `move_done`, cell 28 = 1, cell 12 = 0, `captured`=0, `turn`=1.
- With `turn`=0, click a black piece at (6,0) → `illegal` pulse; state and board unchanged. Select a piece, then click a square whose mask bit is 0 → `illegal`, `highlight` retained.
- Select (1,4), click (1,4) again → `highlight`=0, back in IDLE. Select (1,3), then click (1,4) → reselect: `sel_pos`=12, new mask latched.
- White pawn on (6,2), target (7,3) holds a black rook → cell 59 = 5, `captured`=10. Capture of a king (12) → `game_over`=1, later clicks ignored with no `illegal` pulse.
- `new_game` asserted in the same cycle as a legal target click → no `move_done`, initial board restored, `turn`=0. `rst` pulsed in COMMIT → reset values.
